pixel_combinator: RTL and testbench

Downstream stage of the per-engine pixel queues. Walks the frame in raster order and presents each coordinate to all queues on a shared check bus. Whichever queue reports a front-of-queue match is popped, and its colour is captured. The block emits an in-order pixel stream with start-of-frame and end-of-line markers to the video output.

---
 rtl/pixel_pkg.sv | 22 ++
 rtl/pixel_combinator_if.sv | 26 ++
 rtl/pixel_combinator_raster_counter.sv | 42 ++++
 rtl/pixel_combinator.sv | 162 ++++++++++++++++
 tb/tb_pixel_combinator.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel combinator slice.
package pixel_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RBG_SIZE   = 24;
    localparam int NUM_QUEUES = 4;
    localparam int X_SIZE     = 640;
    localparam int Y_SIZE     = 480;
    localparam int TIMEOUT    = 4096;

    typedef logic [RBG_SIZE-1:0] rgb_t;

    typedef enum logic [1:0] {
        SEEK,
        CAPTURE,
        DRAIN
    } comb_state_t;

    // All-ones never matches a queued coordinate, so it parks the check bus.
    localparam logic [DATA_WIDTH-1:0] COORD_INVALID = '1;

endpackage

// File: rtl/pixel_combinator_if.sv
// Video output stream: colour plus frame markers with a valid/ready handshake.
interface pixel_combinator_if;

    pixel_pkg::rgb_t out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sof;
    logic            out_eol;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eol,
        output out_ready
    );

endinterface

// File: rtl/pixel_combinator_raster_counter.sv
// Raster-order x/y coordinate counter with frame/line position flags.
module raster_counter #(
    parameter int X_SIZE = pixel_pkg::X_SIZE,
    parameter int Y_SIZE = pixel_pkg::Y_SIZE,
    parameter int XW     = $clog2(X_SIZE),
    parameter int YW     = $clog2(Y_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          is_sof,
    output logic          is_eol
);

    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    // Step one pixel per advance, wrapping at end of line and end of frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign is_sof = (x == '0) && (y == '0);
    assign is_eol = (x == X_LAST);

endmodule

// File: rtl/pixel_combinator.sv
// Merges per-engine pixel queues into one raster-ordered video stream.
//
// state   | meaning
// SEEK    | present current coordinate, wait for a queue to match
// CAPTURE | popped colour is now on colour_i; register it, advance coordinate
// DRAIN   | hold the pixel until the downstream accepts it
module pixel_combinator
    import pixel_pkg::*;
#(
    parameter int NUM_QUEUES = pixel_pkg::NUM_QUEUES,
    parameter int X_SIZE     = pixel_pkg::X_SIZE,
    parameter int Y_SIZE     = pixel_pkg::Y_SIZE,
    parameter int TIMEOUT    = pixel_pkg::TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_QUEUES-1:0]   en_i,
    input  rgb_t [NUM_QUEUES-1:0]   colour_i,
    output logic [DATA_WIDTH-1:0]   xpixel_check,
    output logic [DATA_WIDTH-1:0]   ypixel_check,
    pixel_combinator_if.master      vid,
    output logic                    dup_err,
    output logic                    stall_err
);

    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);
    localparam int SW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] STALL_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

    comb_state_t    state_q;
    comb_state_t    state_d;
    logic           advance;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           is_sof;
    logic           is_eol;
    logic           hit;
    logic           multi_hit;
    logic [SW-1:0]  low_idx;
    logic [SW-1:0]  sel_q;
    logic [CW-1:0]  stall_cnt_q;

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .x       (x),
        .y       (y),
        .is_sof  (is_sof),
        .is_eol  (is_eol)
    );

    assign hit       = |en_i;
    assign multi_hit = ($countones(en_i) > 1);

    // Lowest-index matching queue wins when several claim the coordinate.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (en_i[i]) begin
                low_idx = SW'(i);
            end
        end
    end

    // Queues pop on any matching edge, so only SEEK may expose a real coordinate.
    assign xpixel_check = (state_q == SEEK) ? DATA_WIDTH'(x) : COORD_INVALID;
    assign ypixel_check = (state_q == SEEK) ? DATA_WIDTH'(y) : COORD_INVALID;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and coordinate advance strobe.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            SEEK: begin
                if (hit) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                advance = 1'b1;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (vid.out_ready) begin
                    state_d = SEEK;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    // Output pixel register: load in CAPTURE, release on handshake in DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q         <= '0;
            vid.out_data  <= '0;
            vid.out_valid <= 1'b0;
            vid.out_sof   <= 1'b0;
            vid.out_eol   <= 1'b0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (hit) begin
                        sel_q <= low_idx;
                    end
                end
                CAPTURE: begin
                    vid.out_data  <= colour_i[sel_q];
                    vid.out_valid <= 1'b1;
                    vid.out_sof   <= is_sof;
                    vid.out_eol   <= is_eol;
                end
                DRAIN: begin
                    if (vid.out_valid && vid.out_ready) begin
                        vid.out_valid <= 1'b0;
                        vid.out_sof   <= 1'b0;
                        vid.out_eol   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags and saturating no-hit counter, active only while seeking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            dup_err     <= 1'b0;
            stall_err   <= 1'b0;
        end else if (state_q == SEEK) begin
            if (hit) begin
                stall_cnt_q <= '0;
                if (multi_hit) begin
                    dup_err <= 1'b1;
                end
            end else if (stall_cnt_q != STALL_MAX) begin
                stall_cnt_q <= stall_cnt_q + CW'(1);
                if (stall_cnt_q == STALL_LAST) begin
                    stall_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator: behavioural pixel queues feed a small frame and
// the emitted stream is compared with the raster-ordered list of queued pixels.
module tb_pixel_combinator;
    import pixel_pkg::*;

    localparam int NQ    = 4;
    localparam int XS    = 4;
    localparam int YS    = 2;
    localparam int TO    = 8;
    localparam int DEPTH = 16;
    localparam int FRAME = XS * YS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NQ-1:0] en_i, model_en, manual_en;
    rgb_t [NQ-1:0] colour_i, model_colour, manual_colour;
    logic [DATA_WIDTH-1:0] xpc, ypc;
    logic dup_err, stall_err;

    pixel_combinator_if vid();

    pixel_combinator #(.NUM_QUEUES(NQ), .X_SIZE(XS), .Y_SIZE(YS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .en_i(en_i), .colour_i(colour_i),
        .xpixel_check(xpc), .ypixel_check(ypc), .vid(vid),
        .dup_err(dup_err), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Queue contents: coordinate and colour per entry, popped in order.
    logic [31:0] fx [NQ][DEPTH];
    logic [31:0] fy [NQ][DEPTH];
    rgb_t        fc [NQ][DEPTH];
    int          fcount [NQ];
    int          head [NQ];
    rgb_t        exp_c [2*FRAME];

    // A queue claims the bus when its front entry equals the presented coordinate.
    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            model_en[q] = 1'b0;
            if (head[q] < fcount[q])
                model_en[q] = (fx[q][head[q]] == xpc) && (fy[q][head[q]] == ypc);
        end
    end

    // A matching queue pops on the edge and registers the popped colour.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int q = 0; q < NQ; q++) head[q] <= 0;
            model_colour <= '0;
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (model_en[q]) begin
                    model_colour[q] <= fc[q][head[q]];
                    head[q] <= head[q] + 1;
                end
            end
        end
    end

    assign en_i     = model_en | manual_en;
    assign colour_i = model_colour | manual_colour;

    task automatic push(input int q, input int x, input int y, input rgb_t c);
        fx[q][fcount[q]] = 32'(x);
        fy[q][fcount[q]] = 32'(y);
        fc[q][fcount[q]] = c;
        fcount[q]++;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        manual_en = '0;
        manual_colour = '0;
        vid.out_ready = 1'b0;
        for (int q = 0; q < NQ; q++) fcount[q] = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Consume n pixels, comparing each against the raster-ordered expectation.
    task automatic run_stream(input int n, input bit rand_ready);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 400) begin
            @(posedge clk); #1;
            vid.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (vid.out_valid && vid.out_ready) begin
                checks++;
                if (vid.out_data !== exp_c[idx]) $display("FAIL stream_data[%0d]: got %h expected %h", idx, vid.out_data, exp_c[idx]);
                else passes++;
                checks++;
                if (vid.out_sof !== (idx % FRAME == 0)) $display("FAIL stream_sof[%0d]: got %b expected %b", idx, vid.out_sof, (idx % FRAME == 0));
                else passes++;
                checks++;
                if (vid.out_eol !== (idx % XS == XS - 1)) $display("FAIL stream_eol[%0d]: got %b expected %b", idx, vid.out_eol, (idx % XS == XS - 1));
                else passes++;
                idx++;
            end
            cyc++;
        end
        checks++;
        if (idx != n) $display("FAIL stream_count: got %0d pixels expected %0d", idx, n);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (xpc !== 0 || ypc !== 0) $display("FAIL stream_wrap: got (%0h,%0h) expected (0,0)", xpc, ypc);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (vid.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", vid.out_valid); else passes++;
        checks++; if (vid.out_data !== '0) $display("FAIL reset_data: got %h expected 0", vid.out_data); else passes++;
        checks++; if (vid.out_sof !== 1'b0 || vid.out_eol !== 1'b0) $display("FAIL reset_markers: got sof=%b eol=%b expected 0 0", vid.out_sof, vid.out_eol); else passes++;
        checks++; if (dup_err !== 1'b0 || stall_err !== 1'b0) $display("FAIL reset_errs: got dup=%b stall=%b expected 0 0", dup_err, stall_err); else passes++;
        checks++; if (xpc !== 0 || ypc !== 0) $display("FAIL reset_coord: got (%0h,%0h) expected (0,0)", xpc, ypc); else passes++;
    endtask

    task automatic test_single();
        hold_reset();
        push(2, 0, 0, 24'hFF0000);
        vid.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (xpc !== COORD_INVALID || ypc !== COORD_INVALID) $display("FAIL single_capture_bus: got (%h,%h) expected sentinel", xpc, ypc); else passes++;
        checks++; if (vid.out_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", vid.out_valid); else passes++;
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", vid.out_valid); else passes++;
        checks++; if (vid.out_data !== 24'hFF0000) $display("FAIL single_data: got %h expected ff0000", vid.out_data); else passes++;
        checks++; if (vid.out_sof !== 1'b1 || vid.out_eol !== 1'b0) $display("FAIL single_markers: got sof=%b eol=%b expected 1 0", vid.out_sof, vid.out_eol); else passes++;
        checks++; if (xpc !== COORD_INVALID) $display("FAIL single_drain_bus: got %h expected sentinel", xpc); else passes++;
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b0) $display("FAIL single_release: got %b expected 0", vid.out_valid); else passes++;
        checks++; if (xpc !== 1 || ypc !== 0) $display("FAIL single_next_coord: got (%0h,%0h) expected (1,0)", xpc, ypc); else passes++;
    endtask

    // Two frames, each column owned by a random queue, downstream always ready.
    task automatic test_raster();
        int perm [XS];
        hold_reset();
        for (int i = 0; i < XS; i++) perm[i] = i;
        for (int i = XS - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int p = 0; p < 2 * FRAME; p++) begin
            exp_c[p] = rgb_t'($urandom);
            push(perm[p % XS], p % XS, (p / XS) % YS, exp_c[p]);
        end
        reset = 1'b1;
        run_stream(2 * FRAME, 1'b0);
    endtask

    // One frame, random queue per pixel, random backpressure.
    task automatic test_random_backpressure();
        hold_reset();
        for (int p = 0; p < FRAME; p++) begin
            exp_c[p] = rgb_t'($urandom);
            push($urandom_range(0, NQ - 1), p % XS, p / XS, exp_c[p]);
        end
        reset = 1'b1;
        run_stream(FRAME, 1'b1);
    endtask

    task automatic test_backpressure();
        int waited = 0;
        hold_reset();
        push(0, 0, 0, 24'h123456);
        push(0, 1, 0, 24'hABCDEF);
        reset = 1'b1;
        while (!vid.out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (vid.out_valid !== 1'b1) $display("FAIL bp_wait_valid: got %b expected 1", vid.out_valid); else passes++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (vid.out_valid !== 1'b1 || vid.out_data !== 24'h123456 || xpc !== COORD_INVALID || head[0] != 1)
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h x=%h pops=%0d expected 1 123456 sentinel 1", k, vid.out_valid, vid.out_data, xpc, head[0]);
            else passes++;
        end
        vid.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b0 || xpc !== 1) $display("FAIL bp_release: got valid=%b x=%0h expected 0 1", vid.out_valid, xpc); else passes++;
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b1 || vid.out_data !== 24'hABCDEF) $display("FAIL bp_second: got valid=%b data=%h expected 1 abcdef", vid.out_valid, vid.out_data); else passes++;
    endtask

    task automatic test_dup();
        hold_reset();
        manual_colour[1] = 24'h00AA11;
        manual_colour[3] = 24'h330099;
        manual_en = 4'b1010;
        vid.out_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        manual_en = '0;
        checks++; if (dup_err !== 1'b1) $display("FAIL dup_set: got %b expected 1", dup_err); else passes++;
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b1 || vid.out_data !== 24'h00AA11) $display("FAIL dup_sel: got valid=%b data=%h expected 1 00aa11", vid.out_valid, vid.out_data); else passes++;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (dup_err !== 1'b1) $display("FAIL dup_sticky: got %b expected 1", dup_err); else passes++;
        hold_reset();
        checks++; if (dup_err !== 1'b0) $display("FAIL dup_clear: got %b expected 0", dup_err); else passes++;
    endtask

    task automatic test_stall();
        hold_reset();
        vid.out_ready = 1'b1;
        reset = 1'b1;
        repeat (TO - 1) @(posedge clk);
        #1;
        checks++; if (stall_err !== 1'b0) $display("FAIL stall_early: got %b expected 0", stall_err); else passes++;
        @(posedge clk); #1;
        checks++; if (stall_err !== 1'b1) $display("FAIL stall_set: got %b expected 1", stall_err); else passes++;
        manual_colour[2] = 24'h5A5A5A;
        manual_en = 4'b0100;
        @(posedge clk); #1;
        manual_en = '0;
        @(posedge clk); #1;
        checks++; if (vid.out_valid !== 1'b1 || vid.out_data !== 24'h5A5A5A || vid.out_sof !== 1'b1) $display("FAIL stall_recover: got valid=%b data=%h sof=%b expected 1 5a5a5a 1", vid.out_valid, vid.out_data, vid.out_sof); else passes++;
        checks++; if (stall_err !== 1'b1) $display("FAIL stall_sticky: got %b expected 1", stall_err); else passes++;
    endtask

    task automatic test_reset_in_drain();
        int waited = 0;
        hold_reset();
        push(1, 0, 0, 24'hC0FFEE);
        reset = 1'b1;
        while (!vid.out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (vid.out_valid !== 1'b1) $display("FAIL rst_drain_wait: got %b expected 1", vid.out_valid); else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (vid.out_valid !== 1'b0 || vid.out_data !== '0) $display("FAIL rst_drain_async: got valid=%b data=%h expected 0 0", vid.out_valid, vid.out_data); else passes++;
        checks++; if (xpc !== 0 || ypc !== 0) $display("FAIL rst_drain_coord: got (%0h,%0h) expected (0,0)", xpc, ypc); else passes++;
        @(negedge clk);
        for (int q = 0; q < NQ; q++) fcount[q] = 0;
        reset = 1'b1;
        #1;
        checks++; if (xpc !== 0 || ypc !== 0) $display("FAIL rst_drain_seek: got (%h,%h) expected (0,0)", xpc, ypc); else passes++;
    endtask

    initial begin
        manual_en = '0;
        manual_colour = '0;
        vid.out_ready = 1'b0;
        for (int q = 0; q < NQ; q++) fcount[q] = 0;
        test_reset();
        test_single();
        test_raster();
        test_backpressure();
        test_dup();
        test_stall();
        test_random_backpressure();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
